// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, opcode type, flag bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t OP_AND  = 4'b0000;
  localparam alu_op_t OP_OR   = 4'b0001;
  localparam alu_op_t OP_ADD  = 4'b0010;
  localparam alu_op_t OP_XOR  = 4'b0011;
  localparam alu_op_t OP_SLL  = 4'b0100;
  localparam alu_op_t OP_SRL  = 4'b0101;
  localparam alu_op_t OP_SUB  = 4'b0110;
  localparam alu_op_t OP_SLT  = 4'b0111;
  localparam alu_op_t OP_SRA  = 4'b1000;
  localparam alu_op_t OP_SLTU = 4'b1001;
  localparam alu_op_t OP_NOR  = 4'b1010;

  typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
    logic overflow;
    logic illegal;
  } alu_flags_t;

endpackage

// File: rtl/alu_datapath.sv
// Combinational ALU core: result and flags from a, b, opcode.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs continuously.
// Ports: a_i/b_i operands, opcode_i operation, result_o value, flags_o status.
module alu_datapath
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  alu_op_t          opcode_i,
  output logic [WIDTH-1:0] result_o,
  output alu_flags_t       flags_o
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   res;
  logic               carry;
  logic               ovf;
  logic               illegal;

  // Extra top bit holds carry-out for the sum and borrow for the difference.
  assign sum   = {1'b0, a_i} + {1'b0, b_i};
  assign diff  = {1'b0, a_i} - {1'b0, b_i};
  assign shamt = b_i[SHAMT_W-1:0];

  always_comb begin
    res     = '0;
    carry   = 1'b0;
    ovf     = 1'b0;
    illegal = 1'b0;
    // Any opcode that matches no item (unassigned or carrying X/Z) lands in
    // default, so the outputs stay a known zero result with illegal set.
    case (opcode_i)
      OP_AND:  res = a_i & b_i;
      OP_OR:   res = a_i | b_i;
      OP_XOR:  res = a_i ^ b_i;
      OP_NOR:  res = ~(a_i | b_i);
      OP_ADD: begin
        res   = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = (a_i[MSB] == b_i[MSB]) && (sum[MSB] != a_i[MSB]);
      end
      OP_SUB: begin
        res   = diff[WIDTH-1:0];
        carry = diff[WIDTH];
        ovf   = (a_i[MSB] != b_i[MSB]) && (diff[MSB] != a_i[MSB]);
      end
      OP_SLL:  res = a_i << shamt;
      OP_SRL:  res = a_i >> shamt;
      OP_SRA:  res = $unsigned($signed(a_i) >>> shamt);
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      default: illegal = 1'b1;
    endcase
  end

  assign result_o          = res;
  assign flags_o.zero      = (res == '0);
  assign flags_o.negative  = res[MSB];
  assign flags_o.carry     = carry;
  assign flags_o.overflow  = ovf;
  assign flags_o.illegal   = illegal;

endmodule

// File: rtl/alu_unit.sv
// Execute-stage ALU: registers alu_datapath result/flags on enabled edges.
// Latency: 1 cycle from en to valid/result.
// Backpressure: none; en=0 holds result/flags and drops valid next edge.
// Ports: clk, rst_n (async low), en, a, b, opcode in; result, zero, negative,
//        carry, overflow, illegal, valid out (all registered).
module alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             illegal,
  output logic             valid
);

  logic [WIDTH-1:0] result_d, result_q;
  alu_flags_t       flags_d, flags_q;
  logic             valid_q;

  alu_datapath #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_datapath (
    .a_i      (a),
    .b_i      (b),
    .opcode_i (opcode),
    .result_o (result_d),
    .flags_o  (flags_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      flags_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= en;
      if (en) begin
        result_q <= result_d;
        flags_q  <= flags_d;
      end
    end
  end

  assign result   = result_q;
  assign zero     = flags_q.zero;
  assign negative = flags_q.negative;
  assign carry    = flags_q.carry;
  assign overflow = flags_q.overflow;
  assign illegal  = flags_q.illegal;
  assign valid    = valid_q;

endmodule

// File: tb/tb_alu_unit.sv
// Directed bench for alu_unit: reset, every opcode, arithmetic corners,
// illegal/unknown opcodes and enable/hold behaviour.
module tb_alu_unit;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  opcode;
  logic [31:0] result;
  logic        zero, negative, carry, overflow, illegal, valid;

  int checks = 0;
  int errors = 0;

  alu_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .a        (a),
    .b        (b),
    .opcode   (opcode),
    .result   (result),
    .zero     (zero),
    .negative (negative),
    .carry    (carry),
    .overflow (overflow),
    .illegal  (illegal),
    .valid    (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Advance one rising edge and move 1 time unit past it for sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [31:0] av,
                       input logic [31:0] bv, input logic [3:0] op);
    en     = e;
    a      = av;
    b      = bv;
    opcode = op;
  endtask

  // exp_flags order: {zero, negative, carry, overflow, illegal}
  task automatic chk(input string tag, input logic [31:0] exp_res,
                     input logic [4:0] exp_flags, input logic exp_vld);
    logic [37:0] obs, expv;
    obs  = {result, zero, negative, carry, overflow, illegal, valid};
    expv = {exp_res, exp_flags, exp_vld};
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed res=%h flags=%b vld=%b expected res=%h flags=%b vld=%b",
             tag, obs[37:6], obs[5:1], obs[0], expv[37:6], expv[5:1], expv[0]);
    end
  endtask

  logic [3:0]  op_x;
  logic [31:0] x_res;
  logic        x_ill;

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 4'b0000);
    tick();
    tick();
    chk("reset_state", 32'd0, 5'b00000, 1'b0);

    // Release, load a non-zero result, then assert reset between edges.
    rst_n = 1'b1;
    drive(1'b1, 32'h7FFF_FFFF, 32'd1, 4'b0010);
    tick();
    chk("pre_reset_add", 32'h8000_0000, 5'b01010, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 32'd0, 5'b00000, 1'b0);
    tick();
    chk("reset_held_en", 32'd0, 5'b00000, 1'b0);
    #2;
    rst_n = 1'b1;

    drive(1'b1, 32'd15, 32'd10, 4'b0010);
    tick();
    chk("add_15_10", 32'd25, 5'b00000, 1'b1);

    drive(1'b1, 32'd15, 32'd10, 4'b0000); tick();
    chk("and", 32'd10, 5'b00000, 1'b1);
    drive(1'b1, 32'd15, 32'd10, 4'b0001); tick();
    chk("or", 32'd15, 5'b00000, 1'b1);
    drive(1'b1, 32'd15, 32'd10, 4'b0011); tick();
    chk("xor", 32'd5, 5'b00000, 1'b1);
    drive(1'b1, 32'd15, 32'd10, 4'b0100); tick();
    chk("sll", 32'h0000_3C00, 5'b00000, 1'b1);
    drive(1'b1, 32'd15, 32'd10, 4'b0101); tick();
    chk("srl", 32'd0, 5'b10000, 1'b1);
    drive(1'b1, 32'd15, 32'd10, 4'b1010); tick();
    chk("nor", 32'hFFFF_FFF0, 5'b01000, 1'b1);
    drive(1'b1, 32'd15, 32'd10, 4'b0110); tick();
    chk("sub", 32'd5, 5'b00000, 1'b1);
    drive(1'b1, 32'd15, 32'd10, 4'b0111); tick();
    chk("slt_false", 32'd0, 5'b10000, 1'b1);

    drive(1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0010); tick();
    chk("add_carry", 32'd0, 5'b10100, 1'b1);
    drive(1'b1, 32'd0, 32'd1, 4'b0110); tick();
    chk("sub_borrow", 32'hFFFF_FFFF, 5'b01100, 1'b1);
    drive(1'b1, 32'h8000_0000, 32'd1, 4'b0110); tick();
    chk("sub_overflow", 32'h7FFF_FFFF, 5'b00010, 1'b1);
    drive(1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0111); tick();
    chk("slt_neg", 32'd1, 5'b00000, 1'b1);
    drive(1'b1, 32'hFFFF_FFFF, 32'd1, 4'b1001); tick();
    chk("sltu", 32'd0, 5'b10000, 1'b1);
    drive(1'b1, 32'h8000_0000, 32'd4, 4'b1000); tick();
    chk("sra", 32'hF800_0000, 5'b01000, 1'b1);
    // Shift amount 0 via upper-only bits of b: a unchanged.
    drive(1'b1, 32'h0000_1234, 32'h0000_0020, 4'b0100); tick();
    chk("sll_shamt0", 32'h0000_1234, 5'b00000, 1'b1);
    drive(1'b1, 32'h8000_0000, 32'h0000_0040, 4'b1000); tick();
    chk("sra_shamt0", 32'h8000_0000, 5'b01000, 1'b1);

    drive(1'b1, 32'd15, 32'd10, 4'b1100); tick();
    chk("illegal_1100", 32'd0, 5'b10001, 1'b1);
    drive(1'b1, 32'd15, 32'd10, 4'b1111); tick();
    chk("illegal_1111", 32'd0, 5'b10001, 1'b1);

    // Unknown opcode; a two-state simulator collapses X to some value, so
    // the expectation follows whatever the bench actually drove.
    op_x = 4'bxxxx;
    drive(1'b1, 32'd0, 32'd0, op_x);
    if ($isunknown(op_x)) begin
      x_res = 32'd0;
      x_ill = 1'b1;
    end else begin
      x_res = (op_x == 4'b1010) ? 32'hFFFF_FFFF : 32'd0;
      x_ill = (op_x > 4'b1010);
    end
    tick();
    chk("opcode_x", x_res, {(x_res == 32'd0), x_res[31], 2'b00, x_ill}, 1'b1);
    checks++;
    assert (!$isunknown({result, zero, negative, carry, overflow, illegal, valid})) else begin
      errors++;
      $error("FAIL opcode_x_known: observed res=%h expected no X/Z on outputs", result);
    end

    // Enable/hold.
    drive(1'b1, 32'd15, 32'd10, 4'b0010); tick();
    chk("hold_add", 32'd25, 5'b00000, 1'b1);
    drive(1'b0, 32'd99, 32'd1, 4'b0110); tick();
    chk("hold_1", 32'd25, 5'b00000, 1'b0);
    tick();
    chk("hold_2", 32'd25, 5'b00000, 1'b0);
    tick();
    chk("hold_3", 32'd25, 5'b00000, 1'b0);
    drive(1'b1, 32'd15, 32'd10, 4'b0110); tick();
    chk("reenable_sub", 32'd5, 5'b00000, 1'b1);
    drive(1'b0, 32'd0, 32'd0, 4'b0000); tick();
    chk("valid_drop", 32'd5, 5'b00000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
